// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ---- mem_access_unit_pkg : shared widths, size codes and FSM states --------
// ---- Rev 1.0 ---------------------------------------------------------------
package mem_access_unit_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ---- mem_access_unit_if : control-side and memory-side bus ---------------
// ---- Rev 1.0 ---------------------------------------------------------------
interface mem_access_unit_if #(
    parameter int ADDR_W = 8
);
    import mem_access_unit_pkg::*;

    logic              req;
    logic              rw;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic              MFA;
    logic              MFC;
    logic              READ_WRITE;
    logic [1:0]        MEMSIZE;
    logic [ADDR_W-1:0] MEMADD;
    logic [DATA_W-1:0] MEMDOUT;
    logic [DATA_W-1:0] MEMDIN;

    // master = control unit plus memory model, slave = the access unit
    modport master (
        output req, rw, size, sign_ext, addr_in, wdata, MFC, MEMDIN,
        input  busy, done, err, rdata, MFA, READ_WRITE, MEMSIZE, MEMADD, MEMDOUT
    );

    modport slave (
        input  req, rw, size, sign_ext, addr_in, wdata, MFC, MEMDIN,
        output busy, done, err, rdata, MFA, READ_WRITE, MEMSIZE, MEMADD, MEMDOUT
    );

endinterface
`default_nettype wire

// File: rtl/mem_lane_steer.sv
`default_nettype none
// ---- mem_lane_steer : read lane extraction/extension, write replication ---
// ---- Rev 1.0 ---------------------------------------------------------------
module mem_lane_steer
    import mem_access_unit_pkg::*;
(
    input  wire logic [1:0]        addr_lo_i,
    input  wire logic [1:0]        size_i,
    input  wire logic              sign_ext_i,
    input  wire logic [DATA_W-1:0] memdin_i,
    input  wire logic [DATA_W-1:0] wdata_i,
    output logic      [DATA_W-1:0] rdata_o,
    output logic      [DATA_W-1:0] wdata_o,
    output logic                   misalign_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = memdin_i[{addr_lo_i, 3'b000} +: 8];
    assign w_half = memdin_i[{addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        rdata_o    = memdin_i;
        wdata_o    = wdata_i;
        misalign_o = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                rdata_o = {{24{sign_ext_i & w_byte[7]}}, w_byte};
                wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                rdata_o    = {{16{sign_ext_i & w_half[15]}}, w_half};
                wdata_o    = {2{wdata_i[15:0]}};
                misalign_o = addr_lo_i[0];
            end
            SZ_WORD: misalign_o = |addr_lo_i;
            // reserved size code is rejected like a misaligned access
            default: misalign_o = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ---- mem_access_unit : MAR/MBR memory path with MFA/MFC handshake ---------
// ---- Rev 1.0. Define MEM_ACCESS_TIMEOUT_EN for a WAIT-state timeout -------
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 15
) (
    input wire logic        Clk,
    input wire logic        Reset,
    mem_access_unit_if.slave bus
);

    if (ADDR_W < 2 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("mem_access_unit: ADDR_W must be >= 2 and TIMEOUT_CYC >= 1");
    end

    state_t            state_q;
    logic [ADDR_W-1:0] mar_q;
    logic              rw_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [DATA_W-1:0] mbr_q;
    logic [DATA_W-1:0] rdata_q;
    logic              mfa_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic [1:0]        w_addr_lo;
    logic [1:0]        w_size;
    logic              w_sext;
    logic [DATA_W-1:0] w_rdata_ext;
    logic [DATA_W-1:0] w_wdata_rep;
    logic              w_misalign;

    // In IDLE the steer checks the incoming request; afterwards it decodes reads from the latched MAR.
    assign w_addr_lo = (state_q == S_IDLE) ? bus.addr_in[1:0] : mar_q[1:0];
    assign w_size    = (state_q == S_IDLE) ? bus.size         : size_q;
    assign w_sext    = (state_q == S_IDLE) ? bus.sign_ext     : sext_q;

    mem_lane_steer u_steer (
        .addr_lo_i  (w_addr_lo),
        .size_i     (w_size),
        .sign_ext_i (w_sext),
        .memdin_i   (bus.MEMDIN),
        .wdata_i    (bus.wdata),
        .rdata_o    (w_rdata_ext),
        .wdata_o    (w_wdata_rep),
        .misalign_o (w_misalign)
    );

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int               CNT_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] cnt_q;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            mar_q   <= '0;
            rw_q    <= 1'b1;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            mbr_q   <= '0;
            rdata_q <= '0;
            mfa_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.req) begin
                        mar_q  <= bus.addr_in;
                        rw_q   <= bus.rw;
                        size_q <= bus.size;
                        sext_q <= bus.sign_ext;
                        mbr_q  <= w_wdata_rep;
                        if (w_misalign) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                            mfa_q   <= 1'b1;
                            busy_q  <= 1'b1;
`ifdef MEM_ACCESS_TIMEOUT_EN
                            cnt_q   <= '0;
`endif
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.MFC) begin
                        if (rw_q) begin
                            rdata_q <= w_rdata_ext;
                        end
                        state_q <= S_DONE;
                        mfa_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    end else if (cnt_q == C_LAST) begin
                        state_q <= S_DONE;
                        mfa_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
`endif
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.rdata      = rdata_q;
    assign bus.MFA        = mfa_q;
    assign bus.READ_WRITE = rw_q;
    assign bus.MEMSIZE    = size_q;
    assign bus.MEMADD     = mar_q;
    assign bus.MEMDOUT    = mbr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ---- tb_mem_access_unit : directed scoreboard bench for mem_access_unit ---
// ---- Rev 1.0 ---------------------------------------------------------------
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(8)) bus ();

    mem_access_unit #(.ADDR_W(8), .TIMEOUT_CYC(15)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // mfc_cyc = 0 means memory never answers; hold_req re-requests during cycle 1
    task automatic access(input string tag, input logic rw_v, input logic [1:0] sz,
                          input logic sx, input logic [7:0] ad, input logic [31:0] wd,
                          input logic [31:0] din, input int mfc_cyc, input bit hold_mfc,
                          input bit hold_req, input int exp_done, input logic exp_err,
                          input logic [31:0] exp_rd, input logic [31:0] exp_md);
        exp_t e;
        bit   seen = 0;
        @(negedge clk);
        bus.req = 1'b1; bus.rw = rw_v; bus.size = sz; bus.sign_ext = sx;
        bus.addr_in = ad; bus.wdata = wd; bus.MEMDIN = din; bus.MFC = hold_mfc;
        e.err = exp_err; e.rdata = exp_rd;
        sb.push_back(e);
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (hold_req && c == 1) begin
                bus.addr_in = ad ^ 8'h40;
                bus.rw      = ~rw_v;
            end else begin
                bus.req = 1'b0;
            end
            if (c == 1) begin
                chk({tag, ".MEMADD"}, 32'(bus.MEMADD), 32'(ad));
                chk({tag, ".READ_WRITE"}, 32'(bus.READ_WRITE), 32'(rw_v));
                chk({tag, ".MEMSIZE"}, 32'(bus.MEMSIZE), 32'(sz));
                chk({tag, ".MEMDOUT"}, bus.MEMDOUT, exp_md);
            end
            if (bus.done === 1'b1) begin
                seen = 1;
                chk({tag, ".done_cycle"}, 32'(c), 32'(exp_done));
                chk({tag, ".MFA_at_done"}, 32'(bus.MFA), 32'd0);
                chk({tag, ".busy_at_done"}, 32'(bus.busy), 32'd0);
                chk({tag, ".MEMADD_at_done"}, 32'(bus.MEMADD), 32'(ad));
                chk({tag, ".sb_depth"}, 32'(sb.size()), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk({tag, ".err"}, 32'(bus.err), 32'(e.err));
                    chk({tag, ".rdata"}, bus.rdata, e.rdata);
                end
            end else begin
                chk({tag, ".MFA"}, 32'(bus.MFA), 32'(c < exp_done));
                chk({tag, ".busy"}, 32'(bus.busy), 32'(c < exp_done));
                bus.MFC = (c == mfc_cyc) || hold_mfc;
            end
        end
        if (!seen) chk({tag, ".done_seen"}, 32'd0, 32'd1);
        bus.MFC = 1'b0;
        bus.req = 1'b0;
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk({tag, ".idle_MFA"}, 32'(bus.MFA), 32'd0);
            chk({tag, ".idle_done"}, 32'(bus.done), 32'd0);
            chk({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req = 1'b0; bus.rw = 1'b1; bus.size = 2'b00; bus.sign_ext = 1'b0;
        bus.addr_in = '0; bus.wdata = '0; bus.MFC = 1'b0; bus.MEMDIN = '0;
        repeat (2) @(negedge clk);
        chk("rst.MFA", 32'(bus.MFA), 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.err", 32'(bus.err), 32'd0);
        chk("rst.rdata", bus.rdata, 32'd0);
        chk("rst.MEMADD", 32'(bus.MEMADD), 32'd0);
        chk("rst.MEMDOUT", bus.MEMDOUT, 32'd0);
        chk("rst.READ_WRITE", 32'(bus.READ_WRITE), 32'd1);
        chk("rst.MEMSIZE", 32'(bus.MEMSIZE), 32'd0);
        rst = 1'b0;

        // tag rw sz sx addr wdata memdin mfc hold_mfc hold_req done err rdata memdout
        access("rd_word",  1, 2'b10, 0, 8'h10, 32'h11223344, 32'hDEADBEEF, 3, 0, 0, 4, 0, 32'hDEADBEEF, 32'h11223344);
        access("rd_b3_sx", 1, 2'b00, 1, 8'h13, 32'h000000AB, 32'h80FF1234, 1, 0, 0, 2, 0, 32'hFFFFFF80, 32'hABABABAB);
        access("rd_b3_zx", 1, 2'b00, 0, 8'h13, 32'h000000AB, 32'h80FF1234, 1, 0, 0, 2, 0, 32'h00000080, 32'hABABABAB);
        access("rd_b1_sx", 1, 2'b00, 1, 8'h11, 32'h00000000, 32'h80FF1234, 2, 0, 0, 3, 0, 32'h00000012, 32'h00000000);
        access("rd_b2_sx", 1, 2'b00, 1, 8'h12, 32'h00000000, 32'h80FF1234, 2, 0, 0, 3, 0, 32'hFFFFFFFF, 32'h00000000);
        access("rd_h1_sx", 1, 2'b01, 1, 8'h12, 32'h00005678, 32'h80FF1234, 1, 0, 0, 2, 0, 32'hFFFF80FF, 32'h56785678);
        access("rd_h0_sx", 1, 2'b01, 1, 8'h10, 32'h00005678, 32'h80FF1234, 1, 0, 0, 2, 0, 32'h00001234, 32'h56785678);
        access("wr_half",  0, 2'b01, 0, 8'h22, 32'h0000A55A, 32'h0F0F0F0F, 2, 0, 0, 3, 0, 32'h00001234, 32'hA55AA55A);
        access("wr_byte",  0, 2'b00, 0, 8'h31, 32'h000000C3, 32'h0F0F0F0F, 1, 0, 1, 2, 0, 32'h00001234, 32'hC3C3C3C3);
        access("mis_word", 1, 2'b10, 0, 8'h05, 32'h01020304, 32'hFFFFFFFF, 1, 0, 0, 1, 1, 32'h00001234, 32'h01020304);
        access("mis_half", 0, 2'b01, 0, 8'h23, 32'h1234BEEF, 32'hFFFFFFFF, 1, 0, 0, 1, 1, 32'h00001234, 32'hBEEFBEEF);
        access("rsv_size", 1, 2'b11, 0, 8'h00, 32'hCAFEF00D, 32'hFFFFFFFF, 1, 0, 0, 1, 1, 32'h00001234, 32'hCAFEF00D);
        access("rd_busyrq",1, 2'b10, 0, 8'h0C, 32'h0, 32'h76543210, 3, 0, 1, 4, 0, 32'h76543210, 32'h00000000);
        access("mfc_held", 1, 2'b10, 0, 8'h08, 32'h0, 32'h0BADF00D, 1, 1, 0, 2, 0, 32'h0BADF00D, 32'h00000000);

        // reset in the middle of WAIT: MFA and busy fall without a clock, no done follows
        @(negedge clk);
        bus.req = 1'b1; bus.rw = 1'b1; bus.size = 2'b10; bus.addr_in = 8'h30;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        chk("rstmid.MFA_before", 32'(bus.MFA), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid.MFA", 32'(bus.MFA), 32'd0);
        chk("rstmid.busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("rstmid.done", 32'(bus.done), 32'd0);
        chk("rstmid.rdata", bus.rdata, 32'd0);
        rst = 1'b0;
        access("post_rst", 1, 2'b10, 0, 8'h30, 32'h0, 32'h5A5A0FF0, 2, 0, 0, 3, 0, 32'h5A5A0FF0, 32'h00000000);
        access("post_wr",  0, 2'b10, 0, 8'h34, 32'h89ABCDEF, 32'h0, 1, 0, 0, 2, 0, 32'h5A5A0FF0, 32'h89ABCDEF);

`ifdef MEM_ACCESS_TIMEOUT_EN
        access("tmo_err",  1, 2'b10, 0, 8'h40, 32'h0, 32'h12345678, 0, 0, 0, 16, 1, 32'h5A5A0FF0, 32'h00000000);
        access("tmo_race", 1, 2'b10, 0, 8'h44, 32'h0, 32'h12345678, 15, 0, 0, 16, 0, 32'h12345678, 32'h00000000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
